// File: rtl/audio_adc_rx_pkg.sv
// Shared constants and types for the WM8731 ADC capture path.
package audio_pkg;
  localparam int DATA_W_DEF   = 16;
  localparam int PEAK_W       = 4;
  localparam int SYNC_DEPTH   = 2;
  localparam bit LEFT_IS_HIGH = 1'b1;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } rx_state_t;
endpackage

// File: rtl/audio_adc_rx_if.sv
// Parallel stereo sample bus produced by audio_adc_rx.
interface audio_adc_rx_if
  import audio_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic signed [DATA_W-1:0] oLEFT;
  logic signed [DATA_W-1:0] oRIGHT;
  logic                     oVALID;
  logic                     oFRAME_ERR;
  logic        [PEAK_W-1:0] oPEAK_L;
  logic        [PEAK_W-1:0] oPEAK_R;

  modport master (output oLEFT, oRIGHT, oVALID, oFRAME_ERR, oPEAK_L, oPEAK_R);
  modport slave  (input  oLEFT, oRIGHT, oVALID, oFRAME_ERR, oPEAK_L, oPEAK_R);
endinterface

// File: rtl/audio_adc_rx_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous pin followed by one history
// register giving single-cycle rise/fall pulses. DEPTH must be at least 2.
module sync_edge_det
  import audio_pkg::*;
#(
  parameter int DEPTH = SYNC_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);
  logic [DEPTH-1:0] sync_p;
  logic             hist_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
      hist_p <= 1'b0;
    end else begin
      sync_p <= {sync_p[DEPTH-2:0], sig};
      hist_p <= sync_p[DEPTH-1];
    end
  end

  assign rise =  sync_p[DEPTH-1] & ~hist_p;
  assign fall = ~sync_p[DEPTH-1] &  hist_p;
endmodule

// File: rtl/audio_adc_rx.sv
// Deserialises the left-justified WM8731 ADC stream into stereo sample pairs.
// Optional peak meters are built when ADC_PEAK_METER_EN is defined.
module audio_adc_rx
  import audio_pkg::*;
#(
  parameter int DATA_W            = DATA_W_DEF,
  parameter int PEAK_DECAY_FRAMES = 4800
) (
  input  logic           iCLK_18_4,
  input  logic           iRST_N,
  input  logic           iAUD_BCK,
  input  logic           iAUD_LRCK,
  input  logic           iAUD_ADCDAT,
  audio_adc_rx_if.master aud
);
  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic bck_rise, bck_fall_unused, lrck_rise, lrck_fall;
  logic left_start, right_start;
  logic [SYNC_DEPTH-1:0] dat_sync_p;
  logic dat_bit;

  sync_edge_det #(.DEPTH(SYNC_DEPTH)) u_bck_det (
    .clk(iCLK_18_4), .rst_n(iRST_N), .sig(iAUD_BCK),
    .rise(bck_rise), .fall(bck_fall_unused)
  );

  sync_edge_det #(.DEPTH(SYNC_DEPTH)) u_lrck_det (
    .clk(iCLK_18_4), .rst_n(iRST_N), .sig(iAUD_LRCK),
    .rise(lrck_rise), .fall(lrck_fall)
  );

  // Data matches the BCK/LRCK synchroniser depth so the sample lines up with the detected rise.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) dat_sync_p <= '0;
    else         dat_sync_p <= {dat_sync_p[SYNC_DEPTH-2:0], iAUD_ADCDAT};
  end

  assign dat_bit     = dat_sync_p[SYNC_DEPTH-1];
  assign left_start  = LEFT_IS_HIGH ? lrck_rise : lrck_fall;
  assign right_start = LEFT_IS_HIGH ? lrck_fall : lrck_rise;

  rx_state_t               state_q, state_n;
  logic        [CNT_W-1:0] cnt_q, cnt_n;
  logic       [DATA_W-1:0] shift_q, shift_n;
  logic       [DATA_W-1:0] lpend_q, lpend_n;
  logic                    lok_q, lok_n;
  logic signed [DATA_W-1:0] left_q, left_n, right_q, right_n;
  logic                    vld_q, vld_n, err_q, err_n;

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= ALIGN;
      cnt_q   <= '0;
      shift_q <= '0;
      lpend_q <= '0;
      lok_q   <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      shift_q <= shift_n;
      lpend_q <= lpend_n;
      lok_q   <= lok_n;
      left_q  <= left_n;
      right_q <= right_n;
      vld_q   <= vld_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    shift_n = shift_q;
    lpend_n = lpend_q;
    lok_n   = lok_q;
    left_n  = left_q;
    right_n = right_q;
    vld_n   = 1'b0;
    err_n   = 1'b0;

    // Channel boundary is handled first so a coincident BCK rise becomes the new MSB.
    if (left_start && state_q != LEFT) begin
      if (state_q == RIGHT && cnt_q != CNT_FULL) begin
        err_n = 1'b1;
        lok_n = 1'b0;
      end
      state_n = LEFT;
      cnt_n   = '0;
      shift_n = '0;
    end else if (right_start && state_q == LEFT) begin
      if (cnt_q != CNT_FULL) begin
        err_n = 1'b1;
        lok_n = 1'b0;
      end
      state_n = RIGHT;
      cnt_n   = '0;
      shift_n = '0;
    end

    if (bck_rise && state_n != ALIGN && cnt_n != CNT_FULL) begin
      shift_n = {shift_n[DATA_W-2:0], dat_bit};
      cnt_n   = cnt_n + CNT_W'(1);
      if (cnt_n == CNT_FULL) begin
        if (state_n == LEFT) begin
          lpend_n = shift_n;
          lok_n   = 1'b1;
        end else if (lok_n) begin
          left_n  = lpend_n;
          right_n = shift_n;
          vld_n   = 1'b1;
          lok_n   = 1'b0;
        end
      end
    end
  end

  assign aud.oLEFT      = left_q;
  assign aud.oRIGHT     = right_q;
  assign aud.oVALID     = vld_q;
  assign aud.oFRAME_ERR = err_q;

`ifdef ADC_PEAK_METER_EN
  localparam int                DEC_W    = $clog2(PEAK_DECAY_FRAMES + 1);
  localparam logic [DEC_W-1:0]  DEC_LAST = DEC_W'(PEAK_DECAY_FRAMES - 1);
  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]        MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};

  function automatic logic [PEAK_W-1:0] peak_lvl(input logic signed [DATA_W-1:0] s);
    logic [DATA_W-1:0] mag;
    if (s == MOST_NEG)  mag = MAX_POS;
    else if (s < 0)     mag = DATA_W'(-s);
    else                mag = s;
    return PEAK_W'(mag >> (DATA_W - 1 - PEAK_W));
  endfunction

  function automatic logic [PEAK_W-1:0] decay_sat(input logic [PEAK_W-1:0] p);
    return (p == '0) ? '0 : p - PEAK_W'(1);
  endfunction

  logic [DEC_W-1:0]  dec_cnt_q;
  logic [PEAK_W-1:0] pk_l_q, pk_r_q, pk_l_n, pk_r_n, lvl_l, lvl_r;
  logic              dec_hit;

  always_comb begin
    dec_hit = (dec_cnt_q == DEC_LAST);
    lvl_l   = peak_lvl(left_n);
    lvl_r   = peak_lvl(right_n);
    pk_l_n  = dec_hit ? decay_sat(pk_l_q) : pk_l_q;
    pk_r_n  = dec_hit ? decay_sat(pk_r_q) : pk_r_q;
    if (lvl_l > pk_l_n) pk_l_n = lvl_l;
    if (lvl_r > pk_r_n) pk_r_n = lvl_r;
  end

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      dec_cnt_q <= '0;
      pk_l_q    <= '0;
      pk_r_q    <= '0;
    end else if (vld_n) begin
      dec_cnt_q <= dec_hit ? '0 : dec_cnt_q + DEC_W'(1);
      pk_l_q    <= pk_l_n;
      pk_r_q    <= pk_r_n;
    end
  end

  assign aud.oPEAK_L = pk_l_q;
  assign aud.oPEAK_R = pk_r_q;
`else
  // Decay period has no meaning without the meters; kept so the parameter list is build-independent.
  localparam int peak_decay_unused = PEAK_DECAY_FRAMES;
  assign aud.oPEAK_L = '0;
  assign aud.oPEAK_R = '0;
`endif
endmodule

// File: tb/tb_audio_adc_rx.sv
// Randomised bench for audio_adc_rx against a frame-level scoreboard model.
module tb_audio_adc_rx;
  import audio_pkg::*;

  localparam int DW  = 16;
  localparam int PDF = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bck = 1'b0;
  logic lrck = 1'b0;
  logic adcdat = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  audio_adc_rx_if #(.DATA_W(DW)) aud ();

  audio_adc_rx #(.DATA_W(DW), .PEAK_DECAY_FRAMES(PDF)) dut (
    .iCLK_18_4(clk), .iRST_N(rst_n), .iAUD_BCK(bck), .iAUD_LRCK(lrck),
    .iAUD_ADCDAT(adcdat), .aud(aud)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          cyc;
  } pair_t;

  pair_t       exp_q[$];
  pair_t       mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_vld = 0, act_vld = 0, exp_err = 0, act_err = 0;
  bit          aligned, pend_err, left_good;
  logic [15:0] left_word, last_l, last_r;
  int          pk_l, pk_r, frames_seen;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  function automatic int peak_of(input logic [15:0] w);
    int v;
    v = int'($signed(w));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return (v / 2048) % 16;
  endfunction

  task automatic model_reset();
    aligned = 0; pend_err = 0; left_good = 0;
    last_l = '0; last_r = '0;
    pk_l = 0; pk_r = 0; frames_seen = 0;
    exp_q.delete();
  endtask

  task automatic peak_update(input logic [15:0] l, input logic [15:0] r);
    frames_seen++;
`ifdef ADC_PEAK_METER_EN
    if (frames_seen % PDF == 0) begin
      if (pk_l > 0) pk_l--;
      if (pk_r > 0) pk_r--;
    end
    if (peak_of(l) > pk_l) pk_l = peak_of(l);
    if (peak_of(r) > pk_r) pk_r = peak_of(r);
`endif
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (aud.oFRAME_ERR === 1'b1) act_err++;
      if (aud.oVALID === 1'b1) begin
        act_vld++;
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check_val("vld_latency", cyc - mon_e.cyc, 3);
          check_val("vld_left", $unsigned(aud.oLEFT), mon_e.l);
          check_val("vld_right", $unsigned(aud.oRIGHT), mon_e.r);
          peak_update(mon_e.l, mon_e.r);
        end
      end
    end
  end

  // One channel of n BCK periods; the first 16 bits carry w MSB first.
  task automatic send_chan(input bit is_left, input int n, input logic [15:0] w, input bit sim);
    logic lvl;
    int   lo, hi;
    logic d;
    lvl = is_left ? LEFT_IS_HIGH : ~LEFT_IS_HIGH;
    if (rst_n) begin
      if (is_left) begin
        if (aligned && pend_err) exp_err++;
        aligned = 1; pend_err = (n < 16); left_good = (n >= 16); left_word = w;
      end else if (aligned) begin
        if (pend_err) exp_err++;
        pend_err = (n < 16);
      end
    end
    for (int b = 0; b < n; b++) begin
      d  = (b < 16) ? w[15-b] : 1'($urandom);
      lo = $urandom_range(2, 4);
      hi = $urandom_range(2, 4);
      @(negedge clk);
      bck = 1'b0; adcdat = d;
      if (b == 0 && !sim) lrck = lvl;
      repeat (lo - 1) @(negedge clk);
      @(negedge clk);
      bck = 1'b1;
      if (b == 0 && sim) lrck = lvl;
      if (rst_n && !is_left && b == 15 && left_good) begin
        exp_q.push_back('{l: left_word, r: w, cyc: cyc});
        exp_vld++;
        last_l = left_word; last_r = w;
        left_good = 0;
      end
      repeat (hi - 1) @(negedge clk);
    end
  endtask

  task automatic send_frame(input int nl, input logic [15:0] lw, input int nr,
                            input logic [15:0] rw, input bit sim);
    send_chan(1'b1, nl, lw, sim);
    send_chan(1'b0, nr, rw, sim);
  endtask

  task automatic checkpoint(input string tag);
    repeat (10) @(negedge clk);
    check_val({tag, "_vld_cnt"}, act_vld, exp_vld);
    check_val({tag, "_err_cnt"}, act_err, exp_err);
    check_val({tag, "_left"}, $unsigned(aud.oLEFT), last_l);
    check_val({tag, "_right"}, $unsigned(aud.oRIGHT), last_r);
    check_val({tag, "_peak_l"}, aud.oPEAK_L, pk_l);
    check_val({tag, "_peak_r"}, aud.oPEAK_R, pk_r);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_left"}, $unsigned(aud.oLEFT), 0);
    check_val({tag, "_right"}, $unsigned(aud.oRIGHT), 0);
    check_val({tag, "_valid"}, aud.oVALID, 0);
    check_val({tag, "_ferr"}, aud.oFRAME_ERR, 0);
    check_val({tag, "_peak_l"}, aud.oPEAK_L, 0);
    check_val({tag, "_peak_r"}, aud.oPEAK_R, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    // Pins toggle while reset is held; release lands mid right channel.
    send_chan(1'b1, 8, 16'($urandom), 1'b0);
    send_chan(1'b0, 6, 16'($urandom), 1'b0);
    check_reset_vals("rst");
    @(negedge clk) rst_n = 1'b1;
    send_chan(1'b0, 10, 16'($urandom), 1'b0);
    checkpoint("align_wait");

    send_frame(16, 16'h8001, 16, 16'h7FFE, 1'b0);
    checkpoint("first");

    send_frame(16, 16'd1, 16, 16'd2, 1'b0);
    send_frame(16, 16'd3, 16, 16'd4, 1'b0);
    send_frame(16, 16'd5, 16, 16'd6, 1'b0);
    checkpoint("three");

    send_frame(10, 16'($urandom), 16, 16'($urandom), 1'b0);
    checkpoint("short_left");
    send_frame(16, 16'hA5A5, 16, 16'h5A5A, 1'b0);
    checkpoint("recover");

    send_frame(20, 16'h1234, 20, 16'($urandom), 1'b0);
    checkpoint("extra_bits");

    send_frame(16, 16'h7FFF, 16, 16'h8000, 1'b0);
    checkpoint("peak_max");
    for (int i = 0; i < 8; i++) begin
      send_frame(16, 16'h0000, 16, 16'h0000, 1'b0);
      checkpoint("peak_decay");
    end

    send_chan(1'b1, 16, 16'($urandom), 1'b0);
    send_chan(1'b0, 8, 16'($urandom), 1'b0);
    @(negedge clk) rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("mid_rst");
    send_chan(1'b0, 6, 16'($urandom), 1'b0);
    @(negedge clk) rst_n = 1'b1;
    send_chan(1'b0, 10, 16'($urandom), 1'b0);
    checkpoint("post_rst");
    send_frame(16, 16'hCAFE, 16, 16'hBEEF, 1'b0);
    checkpoint("post_rst_frame");

    for (int i = 0; i < 30; i++) begin
      send_frame($urandom_range(10, 20), 16'($urandom), $urandom_range(10, 20),
                 16'($urandom), ($urandom_range(0, 3) == 0));
      checkpoint("rand");
    end
    send_frame(16, 16'($urandom), 16, 16'($urandom), 1'b1);
    checkpoint("final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/audio_adc_rx.md
# audio_adc_rx

Capture side of the WM8731 audio path: deserialises the codec ADC stream (AUD_ADCDAT, clocked by the AUD_BCLK/AUD_ADCLRCK pair that adio_codec drives) into parallel stereo samples in the iCLK_18_4 domain. It sits beside adio_codec under the synthesizer top level. It feeds future record, loop-back and input-effects paths with one validated left/right pair per frame.

## Interface
- DATA_W, 16, bits per channel sample (codec configured 16-bit left-justified)
- PEAK_DECAY_FRAMES, 4800, frames between one-step peak decays (used only with the peak meter)
- iCLK_18_4  in  1  system/audio master clock; all logic on rising edge
- iRST_N  in  1  reset, asynchronous, active-low
- iAUD_BCK  in  1  bit clock from the pin; asynchronous to iCLK_18_4
- iAUD_LRCK  in  1  ADC frame clock from the pin; high = left, low = right
- iAUD_ADCDAT  in  1  serial ADC data from the pin, MSB first
- oLEFT  out  DATA_W  last complete left sample, two's complement
- oRIGHT  out  DATA_W  last complete right sample, two's complement
- oVALID  out  1  one-cycle pulse: oLEFT/oRIGHT updated with a new pair
- oFRAME_ERR  out  1  one-cycle pulse: channel ended with fewer than DATA_W bits
- oPEAK_L, oPEAK_R  out  4  peak level meters (see Configuration)

## Operation
- iAUD_BCK, iAUD_LRCK and iAUD_ADCDAT each pass through a 2-flop synchroniser of equal depth, then one edge-detect register. Data is sampled on a detected BCK rising edge.
- Format: left-justified. The MSB is on the first BCK rise after an LRCK edge. Bits beyond DATA_W within a channel are ignored.
- FSM states:
  - ALIGN (reset state): ignore everything until an LRCK rising edge, then go to LEFT with bit count 0.
  - LEFT: LRCK falling edge goes to RIGHT.
  - RIGHT: LRCK rising edge goes to LEFT.
- Each BCK rise with count < DATA_W shifts the data bit into the shift register and increments the count (saturating at DATA_W).
- When the count reaches DATA_W:
  - In LEFT, the shift register goes to the left-pending register and left_ok is set.
  - In RIGHT with left_ok set, left-pending goes to oLEFT, the shift register goes to oRIGHT, oVALID pulses, and left_ok clears.
- A right channel completing with left_ok clear (e.g. first frame after ALIGN, or after an error) produces no output.
- On an LRCK edge, if the channel just ending has count < DATA_W: oFRAME_ERR pulses, left_ok clears, and the partial word is discarded. The count resets to 0 on every LRCK edge.
- If an LRCK edge and a BCK rise are detected in the same cycle, the LRCK edge is processed first. That BCK rise becomes bit 0 (MSB) of the new channel.
- A reset assertion mid-frame returns to ALIGN immediately; no partial data survives.

## Timing
- Reset values: oLEFT = 0, oRIGHT = 0, oVALID = 0, oFRAME_ERR = 0, oPEAK_* = 0. All synchroniser, count and state registers clear.
- Requirement: at least 4 iCLK_18_4 cycles per BCK period (nominal 6: BCK = 3.072 MHz). Each BCK phase must be at least 2 clocks.
- Pin-to-detect latency is 3 cycles for BCK rise and LRCK edges, with identical data delay so sampling alignment is preserved.
- oLEFT/oRIGHT change and oVALID pulses 1 cycle after the detected BCK rise carrying the right LSB. Outputs then hold until the next pair.
- oFRAME_ERR pulses 1 cycle after the offending detected LRCK edge.

## Configuration
- ADC_PEAK_METER_EN defined:
  - Per channel, the register takes max(current, |sample|[DATA_W-2 -: 4]) on each oVALID. Use magnitude of two's complement, with the most negative value saturating to all ones.
  - A frame counter decrements both meters by 1 (floor 0) every PEAK_DECAY_FRAMES valid pairs; on that frame the decay applies before the max.
- ADC_PEAK_METER_EN undefined: oPEAK_L/oPEAK_R are tied to 0 and there is no counter logic. The ports remain so the top level is unchanged.

## Structure
- Package audio_pkg holds:
  - the DATA_W default
  - the FSM state enum (ALIGN, LEFT, RIGHT)
  - the LRCK polarity constant (LEFT_IS_HIGH = 1)
  - the peak-meter width constant (4)
- Sub-module sync_edge_det (2-flop sync + rise/fall detect, parameterised depth) is instanced for BCK and LRCK. ADCDAT uses its sync path only.

## Test plan
- Reset with pins toggling, release, then left 16'h8001 and right 16'h7FFE at 6 clk/BCK. The first partial frame is discarded; the next full frame gives oVALID once with oLEFT=16'h8001, oRIGHT=16'h7FFE, 1 cycle after the right LSB detect.
- Three consecutive frames with L/R = 1/2, 3/4, 5/6 give three oVALID pulses with matching pairs and no oFRAME_ERR.
- LRCK falls after only 10 left bits: oFRAME_ERR pulses once and there is no oVALID for that frame. The following clean frame outputs normally.
- 20 BCK rises per channel, with the first 16 bits carrying 16'h1234: oLEFT=16'h1234, and the extra bits are ignored.
- Assert iRST_N low mid-right-channel, then release: all outputs are 0, and ALIGN waits for the LRCK rise before any oVALID.
- With ADC_PEAK_METER_EN and PEAK_DECAY_FRAMES=4:
  - A pair (16'h7FFF, 16'h8000) sets oPEAK_L=4'hF and oPEAK_R=4'hF.
  - Zero-sample frames then decay the meters by 1 every 4 frames.
  - Without the macro, both meters stay 0.
